// File: rtl/hicore_lsu_if.sv
// Bundle of the LSU's pipe, data-bus and write-back signals.
// master = the LSU, slave = the surrounding pipeline/bus/ROB.
interface hicore_lsu_if #(
    parameter int INFO_W = 50,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  i_agu2lsu_valid;
    logic                  i_agu2lsu_ready;
    logic                  i_agu2lsu_cancel;
    logic                  i_agu2lsu_read;
    logic                  i_agu2lsu_unsigned;
    logic                  i_agu2lsu_word_access;
    logic                  i_agu2lsu_short_access;
    logic                  i_agu2lsu_byte_access;
    logic [ADDR_W-1:0]     i_agu2lsu_addr;
    logic [DATA_W-1:0]     i_agu2lsu_wdata;
    logic [DATA_W/8-1:0]   i_agu2lsu_wmask;
    logic [INFO_W-1:0]     i_agu2lsu_info;

    logic                  o_lsu2mem_cmd_valid;
    logic                  o_lsu2mem_cmd_ready;
    logic                  o_lsu2mem_cmd_read;
    logic [ADDR_W-1:0]     o_lsu2mem_cmd_addr;
    logic [DATA_W-1:0]     o_lsu2mem_cmd_wdata;
    logic [DATA_W/8-1:0]   o_lsu2mem_cmd_wmask;

    logic                  i_mem2lsu_rsp_valid;
    logic                  i_mem2lsu_rsp_ready;
    logic [DATA_W-1:0]     i_mem2lsu_rsp_rdata;
    logic                  i_mem2lsu_rsp_err;

    logic                  o_lsu2rob_valid;
    logic                  o_lsu2rob_ready;
    logic [DATA_W-1:0]     o_lsu2rob_wdata;
    logic [INFO_W-1:0]     o_lsu2rob_info;

    logic                  flush;

    modport master (
        input  i_agu2lsu_valid, i_agu2lsu_cancel, i_agu2lsu_read, i_agu2lsu_unsigned,
               i_agu2lsu_word_access, i_agu2lsu_short_access, i_agu2lsu_byte_access,
               i_agu2lsu_addr, i_agu2lsu_wdata, i_agu2lsu_wmask, i_agu2lsu_info,
               o_lsu2mem_cmd_ready, i_mem2lsu_rsp_valid, i_mem2lsu_rsp_rdata,
               i_mem2lsu_rsp_err, o_lsu2rob_ready, flush,
        output i_agu2lsu_ready, o_lsu2mem_cmd_valid, o_lsu2mem_cmd_read,
               o_lsu2mem_cmd_addr, o_lsu2mem_cmd_wdata, o_lsu2mem_cmd_wmask,
               i_mem2lsu_rsp_ready, o_lsu2rob_valid, o_lsu2rob_wdata, o_lsu2rob_info
    );

    modport slave (
        output i_agu2lsu_valid, i_agu2lsu_cancel, i_agu2lsu_read, i_agu2lsu_unsigned,
               i_agu2lsu_word_access, i_agu2lsu_short_access, i_agu2lsu_byte_access,
               i_agu2lsu_addr, i_agu2lsu_wdata, i_agu2lsu_wmask, i_agu2lsu_info,
               o_lsu2mem_cmd_ready, i_mem2lsu_rsp_valid, i_mem2lsu_rsp_rdata,
               i_mem2lsu_rsp_err, o_lsu2rob_ready, flush,
        input  i_agu2lsu_ready, o_lsu2mem_cmd_valid, o_lsu2mem_cmd_read,
               o_lsu2mem_cmd_addr, o_lsu2mem_cmd_wdata, o_lsu2mem_cmd_wmask,
               i_mem2lsu_rsp_ready, o_lsu2rob_valid, o_lsu2rob_wdata, o_lsu2rob_info
    );
endinterface

// File: rtl/hicore_lsu.sv
// Blocking single-outstanding load/store unit: one bus transaction per request.
// Optional HICORE_LSU_BUS_ERR_EN turns bus errors into load/store access faults.
module hicore_lsu #(
    parameter int INFO_W = 50,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic         clk,
    input logic         rst,
    hicore_lsu_if.master bus
);
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [2:0] {IDLE, CMD, RSP, DRAIN, WB} state_t;
    state_t state, state_nxt;

    logic                read_l, uns_l, word_l, short_l, byte_l;
    logic [ADDR_W-1:0]   addr_l;
    logic [DATA_W-1:0]   wdata_l;
    logic [MASK_W-1:0]   wmask_l;
    logic [INFO_W-1:0]   info_l;
    logic [DATA_W-1:0]   rob_wdata;
    logic [INFO_W-1:0]   rob_info;

    logic agu_ready, cmd_valid, rsp_ready, rob_valid;
    logic take_req, take_excp, take_rsp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Flush wins over every handshake; a flush in RSP still owes a response
    // unless that response lands in the same cycle.
    always_comb begin
        state_nxt = state;
        agu_ready = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        rob_valid = 1'b0;
        take_req  = 1'b0;
        take_excp = 1'b0;
        take_rsp  = 1'b0;
        case (state)
            IDLE: begin
                agu_ready = 1'b1;
                if (bus.i_agu2lsu_valid && !bus.i_agu2lsu_cancel && !bus.flush) begin
                    take_req = 1'b1;
                    if (|bus.i_agu2lsu_info[15:0]) begin
                        take_excp = 1'b1;
                        state_nxt = WB;
                    end else begin
                        state_nxt = CMD;
                    end
                end
            end
            CMD: begin
                cmd_valid = 1'b1;
                if (bus.flush)                    state_nxt = IDLE;
                else if (bus.o_lsu2mem_cmd_ready) state_nxt = RSP;
            end
            RSP: begin
                rsp_ready = 1'b1;
                if (bus.flush) begin
                    state_nxt = bus.i_mem2lsu_rsp_valid ? IDLE : DRAIN;
                end else if (bus.i_mem2lsu_rsp_valid) begin
                    take_rsp  = 1'b1;
                    state_nxt = WB;
                end
            end
            DRAIN: begin
                rsp_ready = 1'b1;
                if (bus.i_mem2lsu_rsp_valid) state_nxt = IDLE;
            end
            WB: begin
                rob_valid = 1'b1;
                if (bus.flush || bus.o_lsu2rob_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Load alignment and extension from the latched address and size.
    logic [DATA_W-1:0] byte_sh, half_sh, aligned;
    always_comb begin
        byte_sh = bus.i_mem2lsu_rsp_rdata >> {addr_l[1:0], 3'b000};
        half_sh = bus.i_mem2lsu_rsp_rdata >> {addr_l[1], 4'b0000};
        aligned = '0;
        if (word_l)  aligned = bus.i_mem2lsu_rsp_rdata;
        if (short_l) aligned = {{(DATA_W-16){!uns_l && half_sh[15]}}, half_sh[15:0]};
        if (byte_l)  aligned = {{(DATA_W-8){!uns_l && byte_sh[7]}}, byte_sh[7:0]};
    end

    logic [INFO_W-1:0] err_bits;
    logic              err_kill;
`ifdef HICORE_LSU_BUS_ERR_EN
    always_comb begin
        err_bits = '0;
        err_kill = bus.i_mem2lsu_rsp_err;
        if (bus.i_mem2lsu_rsp_err) begin
            if (read_l) err_bits[5] = 1'b1;
            else        err_bits[7] = 1'b1;
        end
    end
`else
    logic unused_rsp_err;
    assign unused_rsp_err = bus.i_mem2lsu_rsp_err;
    assign err_bits = '0;
    assign err_kill = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_l    <= 1'b0;
            uns_l     <= 1'b0;
            word_l    <= 1'b0;
            short_l   <= 1'b0;
            byte_l    <= 1'b0;
            addr_l    <= '0;
            wdata_l   <= '0;
            wmask_l   <= '0;
            info_l    <= '0;
            rob_wdata <= '0;
            rob_info  <= '0;
        end else begin
            if (take_req) begin
                read_l  <= bus.i_agu2lsu_read;
                uns_l   <= bus.i_agu2lsu_unsigned;
                word_l  <= bus.i_agu2lsu_word_access;
                short_l <= bus.i_agu2lsu_short_access;
                byte_l  <= bus.i_agu2lsu_byte_access;
                addr_l  <= bus.i_agu2lsu_addr;
                wdata_l <= bus.i_agu2lsu_wdata;
                wmask_l <= bus.i_agu2lsu_wmask;
                info_l  <= bus.i_agu2lsu_info;
            end
            if (take_excp) begin
                rob_wdata <= '0;
                rob_info  <= bus.i_agu2lsu_info;
            end
            if (take_rsp) begin
                rob_wdata <= (read_l && !err_kill) ? aligned : '0;
                rob_info  <= info_l | err_bits;
            end
        end
    end

    assign bus.i_agu2lsu_ready     = agu_ready;
    assign bus.o_lsu2mem_cmd_valid = cmd_valid;
    assign bus.o_lsu2mem_cmd_read  = read_l;
    assign bus.o_lsu2mem_cmd_addr  = addr_l;
    assign bus.o_lsu2mem_cmd_wdata = wdata_l;
    assign bus.o_lsu2mem_cmd_wmask = wmask_l;
    assign bus.i_mem2lsu_rsp_ready = rsp_ready;
    assign bus.o_lsu2rob_valid     = rob_valid;
    assign bus.o_lsu2rob_wdata     = rob_wdata;
    assign bus.o_lsu2rob_info      = rob_info;
endmodule

// File: tb/tb_hicore_lsu.sv
// Scoreboard bench for hicore_lsu: directed timing/flush cases, then random traffic
// against a reference model of load alignment and error reporting.
module tb_hicore_lsu;
    localparam int INFO_W = 50;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
`ifdef HICORE_LSU_BUS_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hicore_lsu_if #(.INFO_W(INFO_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    hicore_lsu #(.INFO_W(INFO_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct {
        bit          read;
        bit          uns;
        bit [1:0]    sz;      // 0 byte, 1 short, 2 word
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [49:0] info;
        bit          cancel;
        bit          fl;
    } req_t;
    typedef struct {
        logic [31:0] wdata;
        logic [49:0] info;
    } rob_t;

    req_t pend[$];
    rob_t robq[$];
    int   errors = 0;
    int   checks = 0;
    bit   mem_auto = 1'b0;
    bit   rob_rand = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: pick the addressed byte/halfword arithmetically and sign-extend by value.
    function automatic logic [31:0] ref_load(input req_t r, input logic [31:0] rd);
        longint unsigned v;
        case (r.sz)
            2'd0: begin
                v = longint'(rd / (32'd1 << ((r.addr % 4) * 8))) % 256;
                if (!r.uns && v >= 128) v = v + 64'hFFFF_FF00;
            end
            2'd1: begin
                v = longint'(((r.addr % 4) >= 2) ? rd / 65536 : rd) % 65536;
                if (!r.uns && v >= 32768) v = v + 64'hFFFF_0000;
            end
            default: v = longint'(rd);
        endcase
        return v[31:0];
    endfunction

    function automatic rob_t ref_rob(input req_t r, input logic [31:0] rd, input bit err);
        rob_t o;
        o.info  = r.info;
        o.wdata = r.read ? ref_load(r, rd) : 32'h0;
        if (ERR_EN && err) begin
            o.wdata = 32'h0;
            if (r.read) o.info[5] = 1'b1;
            else        o.info[7] = 1'b1;
        end
        return o;
    endfunction

    function automatic req_t mk(input bit rd, input bit uns, input bit [1:0] sz,
                                input logic [31:0] addr, input logic [3:0] wm,
                                input logic [49:0] info);
        req_t r;
        r.read = rd; r.uns = uns; r.sz = sz; r.addr = addr; r.wdata = 32'hA5A5_5A5A;
        r.wmask = wm; r.info = info; r.cancel = 1'b0; r.fl = 1'b0;
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.read  = 1'($urandom);
        r.uns   = 1'($urandom);
        r.sz    = 2'($urandom_range(0, 2));
        r.addr  = $urandom;
        if (r.sz >= 2'd1) r.addr[0] = 1'b0;
        if (r.sz == 2'd2) r.addr[1] = 1'b0;
        r.wdata = $urandom;
        r.wmask = 4'($urandom);
        r.info  = 50'({$urandom, $urandom});
        r.info[15:0] = ($urandom % 8 == 0) ? 16'($urandom_range(1, 65535)) : 16'h0;
        r.cancel = ($urandom % 10 == 0);
        r.fl     = 1'b0;
        return r;
    endfunction

    task automatic issue(input req_t r, input bit track);
        int n = 0;
        @(negedge clk);
        while (!bus.i_agu2lsu_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("issue_timeout", 64'd0, 64'd1);
        bus.i_agu2lsu_valid        = 1'b1;
        bus.i_agu2lsu_read         = r.read;
        bus.i_agu2lsu_unsigned     = r.uns;
        bus.i_agu2lsu_byte_access  = (r.sz == 2'd0);
        bus.i_agu2lsu_short_access = (r.sz == 2'd1);
        bus.i_agu2lsu_word_access  = (r.sz == 2'd2);
        bus.i_agu2lsu_addr         = r.addr;
        bus.i_agu2lsu_wdata        = r.wdata;
        bus.i_agu2lsu_wmask        = r.wmask;
        bus.i_agu2lsu_info         = r.info;
        bus.i_agu2lsu_cancel       = r.cancel;
        bus.flush                  = r.fl;
        if (track && !r.cancel && !r.fl) begin
            if (r.info[15:0] != 16'h0) robq.push_back('{wdata: 32'h0, info: r.info});
            else                        pend.push_back(r);
        end
        @(posedge clk);
        #1;
        bus.i_agu2lsu_valid  = 1'b0;
        bus.i_agu2lsu_cancel = 1'b0;
        bus.flush            = 1'b0;
    endtask

    // Zero-wait memory transaction with cycle-exact latency checks.
    task automatic dir_mem(input string nm, input req_t r, input logic [31:0] rd, input bit err,
                           input logic [31:0] exp_w, input logic [49:0] exp_i);
        issue(r, 1'b0);
        @(negedge clk);
        chk({nm, "_cmd_valid_n1"}, 64'(bus.o_lsu2mem_cmd_valid), 64'd1);
        chk({nm, "_cmd_read"}, 64'(bus.o_lsu2mem_cmd_read), 64'(r.read));
        chk({nm, "_cmd_addr"}, 64'(bus.o_lsu2mem_cmd_addr), 64'(r.addr));
        chk({nm, "_cmd_wmask"}, 64'(bus.o_lsu2mem_cmd_wmask), 64'(r.wmask));
        bus.o_lsu2mem_cmd_ready = 1'b1;
        @(posedge clk);
        #1 bus.o_lsu2mem_cmd_ready = 1'b0;
        @(negedge clk);
        chk({nm, "_rsp_ready"}, 64'(bus.i_mem2lsu_rsp_ready), 64'd1);
        bus.i_mem2lsu_rsp_valid = 1'b1;
        bus.i_mem2lsu_rsp_rdata = rd;
        bus.i_mem2lsu_rsp_err   = err;
        robq.push_back('{wdata: exp_w, info: exp_i});
        @(posedge clk);
        #1;
        bus.i_mem2lsu_rsp_valid = 1'b0;
        bus.i_mem2lsu_rsp_err   = 1'b0;
        @(negedge clk);
        chk({nm, "_rob_valid_n3"}, 64'(bus.o_lsu2rob_valid), 64'd1);
        @(posedge clk);
        #1;
    endtask

    // ROB monitor: decides ready for the coming edge, then scores the handshake.
    initial begin
        rob_t e;
        forever begin
            @(negedge clk);
            bus.o_lsu2rob_ready = rob_rand ? ($urandom % 4 != 0) : 1'b1;
            if (!rst && bus.o_lsu2rob_valid && bus.o_lsu2rob_ready) begin
                if (robq.size() == 0) begin
                    chk("rob_unexpected", 64'd1, 64'd0);
                end else begin
                    e = robq.pop_front();
                    chk("rob_wdata", 64'(bus.o_lsu2rob_wdata), 64'(e.wdata));
                    chk("rob_info", 64'(bus.o_lsu2rob_info), 64'(e.info));
                end
            end
        end
    end

    // Random-latency memory model used during the random phase.
    initial begin
        req_t        r;
        bit          have;
        bit          err;
        logic [31:0] rd;
        forever begin
            @(negedge clk);
            if (mem_auto && !rst) begin
                bus.o_lsu2mem_cmd_ready = ($urandom % 3 != 0);
                if (bus.o_lsu2mem_cmd_valid && bus.o_lsu2mem_cmd_ready) begin
                    have = (pend.size() != 0);
                    if (!have) begin
                        chk("cmd_unexpected", 64'd1, 64'd0);
                    end else begin
                        r = pend.pop_front();
                        chk("cmd_read", 64'(bus.o_lsu2mem_cmd_read), 64'(r.read));
                        chk("cmd_addr", 64'(bus.o_lsu2mem_cmd_addr), 64'(r.addr));
                        chk("cmd_wdata", 64'(bus.o_lsu2mem_cmd_wdata), 64'(r.wdata));
                        chk("cmd_wmask", 64'(bus.o_lsu2mem_cmd_wmask), 64'(r.wmask));
                    end
                    @(posedge clk);
                    #1 bus.o_lsu2mem_cmd_ready = 1'b0;
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    rd  = $urandom;
                    err = ($urandom % 5 == 0);
                    bus.i_mem2lsu_rsp_valid = 1'b1;
                    bus.i_mem2lsu_rsp_rdata = rd;
                    bus.i_mem2lsu_rsp_err   = err;
                    if (have) robq.push_back(ref_rob(r, rd, err));
                    @(posedge clk);
                    #1;
                    bus.i_mem2lsu_rsp_valid = 1'b0;
                    bus.i_mem2lsu_rsp_err   = 1'b0;
                end
            end
        end
    end

    initial begin
        req_t        r;
        logic [49:0] inf;
        int          n;
        bus.i_agu2lsu_valid = 1'b0; bus.i_agu2lsu_cancel = 1'b0; bus.i_agu2lsu_read = 1'b0;
        bus.i_agu2lsu_unsigned = 1'b0; bus.i_agu2lsu_word_access = 1'b0;
        bus.i_agu2lsu_short_access = 1'b0; bus.i_agu2lsu_byte_access = 1'b0;
        bus.i_agu2lsu_addr = '0; bus.i_agu2lsu_wdata = '0; bus.i_agu2lsu_wmask = '0;
        bus.i_agu2lsu_info = '0; bus.o_lsu2mem_cmd_ready = 1'b0; bus.i_mem2lsu_rsp_valid = 1'b0;
        bus.i_mem2lsu_rsp_rdata = '0; bus.i_mem2lsu_rsp_err = 1'b0; bus.flush = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_agu_ready", 64'(bus.i_agu2lsu_ready), 64'd1);
        chk("rst_cmd_valid", 64'(bus.o_lsu2mem_cmd_valid), 64'd0);
        chk("rst_rsp_ready", 64'(bus.i_mem2lsu_rsp_ready), 64'd0);
        chk("rst_rob_valid", 64'(bus.o_lsu2rob_valid), 64'd0);
        chk("rst_rob_wdata", 64'(bus.o_lsu2rob_wdata), 64'd0);
        chk("rst_rob_info", 64'(bus.o_lsu2rob_info), 64'd0);
        chk("rst_cmd_addr", 64'(bus.o_lsu2mem_cmd_addr), 64'd0);
        rst = 1'b0;

        inf = 50'h1_2345_6789_0000;
        r = mk(1'b1, 1'b0, 2'd2, 32'h100, 4'hF, inf);
        dir_mem("word_ld", r, 32'h89AB_CDEF, 1'b0, 32'h89AB_CDEF, inf);
        r = mk(1'b1, 1'b0, 2'd0, 32'h103, 4'hF, inf);
        dir_mem("sbyte_ld", r, 32'h8011_2233, 1'b0, 32'hFFFF_FF80, inf);
        r = mk(1'b1, 1'b1, 2'd0, 32'h103, 4'hF, inf);
        dir_mem("ubyte_ld", r, 32'h8011_2233, 1'b0, 32'h0000_0080, inf);
        r = mk(1'b1, 1'b0, 2'd1, 32'h102, 4'hF, inf);
        dir_mem("sshort_ld", r, 32'h9234_5678, 1'b0, 32'hFFFF_9234, inf);
        r = mk(1'b0, 1'b0, 2'd1, 32'h102, 4'b1100, inf);
        dir_mem("short_st", r, 32'hDEAD_BEEF, 1'b0, 32'h0, inf);

        // Upstream exception: straight to write-back, no bus command.
        r = mk(1'b1, 1'b0, 2'd2, 32'h101, 4'hF, inf | 50'h10);
        robq.push_back('{wdata: 32'h0, info: inf | 50'h10});
        issue(r, 1'b0);
        @(negedge clk);
        chk("excp_no_cmd", 64'(bus.o_lsu2mem_cmd_valid), 64'd0);
        chk("excp_rob_n1", 64'(bus.o_lsu2rob_valid), 64'd1);
        @(posedge clk);
        #1;

        // Flush in RSP: response two cycles later is drained, ready held low.
        r = mk(1'b1, 1'b0, 2'd2, 32'h200, 4'hF, inf);
        issue(r, 1'b0);
        @(negedge clk);
        bus.o_lsu2mem_cmd_ready = 1'b1;
        @(posedge clk);
        #1 bus.o_lsu2mem_cmd_ready = 1'b0;
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        chk("drain_agu_ready", 64'(bus.i_agu2lsu_ready), 64'd0);
        chk("drain_rsp_ready", 64'(bus.i_mem2lsu_rsp_ready), 64'd1);
        @(negedge clk);
        chk("drain_agu_ready2", 64'(bus.i_agu2lsu_ready), 64'd0);
        bus.i_mem2lsu_rsp_valid = 1'b1;
        bus.i_mem2lsu_rsp_rdata = 32'h1234_5678;
        @(posedge clk);
        #1 bus.i_mem2lsu_rsp_valid = 1'b0;
        @(negedge clk);
        chk("drain_done_ready", 64'(bus.i_agu2lsu_ready), 64'd1);
        chk("drain_no_rob", 64'(bus.o_lsu2rob_valid), 64'd0);

        // Flush while the command waits: no command issued.
        r = mk(1'b0, 1'b0, 2'd2, 32'h300, 4'hF, inf);
        issue(r, 1'b0);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_cmd_valid", 64'(bus.o_lsu2mem_cmd_valid), 64'd0);
        chk("flush_cmd_ready", 64'(bus.i_agu2lsu_ready), 64'd1);

        // Cancelled request and flush-at-accept are both dropped.
        r = mk(1'b1, 1'b0, 2'd2, 32'h400, 4'hF, inf);
        r.cancel = 1'b1;
        issue(r, 1'b0);
        @(negedge clk);
        chk("cancel_cmd", 64'(bus.o_lsu2mem_cmd_valid), 64'd0);
        chk("cancel_ready", 64'(bus.i_agu2lsu_ready), 64'd1);
        r = mk(1'b1, 1'b0, 2'd2, 32'h404, 4'hF, inf | 50'h4);
        r.fl = 1'b1;
        issue(r, 1'b0);
        @(negedge clk);
        chk("flush_idle_cmd", 64'(bus.o_lsu2mem_cmd_valid), 64'd0);
        chk("flush_idle_rob", 64'(bus.o_lsu2rob_valid), 64'd0);

        // Bus error on a load and on a store.
        r = mk(1'b1, 1'b0, 2'd2, 32'h500, 4'hF, inf);
        dir_mem("err_ld", r, 32'h1122_3344, 1'b1,
                ERR_EN ? 32'h0 : 32'h1122_3344, ERR_EN ? (inf | 50'h20) : inf);
        r = mk(1'b0, 1'b0, 2'd2, 32'h504, 4'hF, inf);
        dir_mem("err_st", r, 32'h1122_3344, 1'b1, 32'h0, ERR_EN ? (inf | 50'h80) : inf);

        mem_auto = 1'b1;
        rob_rand = 1'b1;
        for (int i = 0; i < 200; i++) issue(rand_req(), 1'b1);
        n = 0;
        while ((robq.size() != 0 || pend.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(n >= 500), 64'd0);
        chk("left_rob", 64'(robq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hicore_lsu.md
# hicore_lsu

Load/store unit that consumes address-generated memory requests from the AGU-to-LSU pipe stage and performs one data-bus transaction per request. It aligns and sign- or zero-extends load data, attaches bus-error exceptions, and returns the completed result to the ROB write-back port. It is a blocking, single-outstanding unit. Flush drops the in-flight operation and drains any response already owed by the bus.

## Interface
- `INFO_W`, default 50: width of the `{rob_ptr, pc, irq, excp}` info bundle. `excp` is bits [15:0].
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width. Mask width is `DATA_W/8`.

Ports (name, direction, width, meaning):
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `i_agu2lsu_valid` in 1: request valid.
- `i_agu2lsu_ready` out 1: request accepted when high together with valid.
- `i_agu2lsu_cancel` in 1: request is killed; accept it and discard it.
- `i_agu2lsu_read` in 1: 1 = load, 0 = store.
- `i_agu2lsu_unsigned` in 1: zero-extend the load result.
- `i_agu2lsu_word_access`, `i_agu2lsu_short_access`, `i_agu2lsu_byte_access` in 1 each: access size, one-hot.
- `i_agu2lsu_addr` in `ADDR_W`: byte address.
- `i_agu2lsu_wdata` in `DATA_W`: store data, already lane-replicated.
- `i_agu2lsu_wmask` in `DATA_W/8`: store byte enables.
- `i_agu2lsu_info` in `INFO_W`: rob_ptr/pc/irq/excp bundle.
- `o_lsu2mem_cmd_valid` out 1; `o_lsu2mem_cmd_ready` in 1: bus command handshake.
- `o_lsu2mem_cmd_read` out 1; `o_lsu2mem_cmd_addr` out `ADDR_W`; `o_lsu2mem_cmd_wdata` out `DATA_W`; `o_lsu2mem_cmd_wmask` out `DATA_W/8`.
- `i_mem2lsu_rsp_valid` in 1: bus response valid.
- `i_mem2lsu_rsp_ready` out 1: bus response accepted.
- `i_mem2lsu_rsp_rdata` in `DATA_W`; `i_mem2lsu_rsp_err` in 1: bus access error.
- `o_lsu2rob_valid` out 1; `o_lsu2rob_ready` in 1: write-back handshake.
- `o_lsu2rob_wdata` out `DATA_W`: aligned load result. Zero for stores.
- `o_lsu2rob_info` out `INFO_W`: info bundle with the updated excp field.
- `flush` in 1: commit flush.

## Operation
States:
- **IDLE**:
  - `i_agu2lsu_ready` = 1.
  - On handshake, the request is latched.
  - If `i_agu2lsu_cancel`=1, or `flush`=1 in the same cycle, the request is dropped and the FSM stays in IDLE.
  - Else, if `excp` is non-zero, go to WB with no bus access.
  - Else go to CMD.
- **CMD**:
  - `o_lsu2mem_cmd_valid` = 1. Command fields are driven from the latch and held stable until the handshake.
  - On handshake, go to RSP.
  - On `flush` before the handshake, go to IDLE and issue no command.
- **RSP**:
  - `i_mem2lsu_rsp_ready` = 1.
  - On response, capture the aligned data and error, then go to WB.
  - On `flush` before the response, go to DRAIN.
- **DRAIN**:
  - `i_mem2lsu_rsp_ready` = 1. The response is accepted and discarded, then go to IDLE.
  - `i_agu2lsu_ready` = 0.
- **WB**:
  - `o_lsu2rob_valid` = 1. Outputs are held stable until `o_lsu2rob_ready`.
  - On handshake, go to IDLE.
  - On `flush`, go to IDLE without write-back.

Load alignment, with `sh = addr[1:0]*8`:
- Byte: `rdata[sh+7:sh]`, extended using bit 7, or with zeros if unsigned.
- Short: `rdata[{addr[1],4'b0}+15 -: 16]`, extended using bit 15.
- Word: passthrough.

Flush has priority over every other transition. An exception arriving from upstream is passed through unchanged.

## Timing
- Reset values:
  - State = IDLE.
  - `i_agu2lsu_ready`=1. All other outputs are 0: `o_lsu2mem_cmd_valid`, `i_mem2lsu_rsp_ready`, `o_lsu2rob_valid`, and all data and info outputs.
- Request accepted at cycle N gives `o_lsu2mem_cmd_valid` at N+1.
- A response is legal no earlier than the cycle after the command handshake.
- A response at cycle M gives `o_lsu2rob_valid` at M+1.
- Minimum latency from accept to write-back is 3 cycles with zero-wait memory. An excepting request reaches write-back at N+1.
- Throughput is one request per 4 cycles at best. There is no overlap between requests.
- Reset asserted mid-operation returns the FSM to IDLE immediately. Any bus response that was owed is not tracked.

## Configuration
- Macro `HICORE_LSU_BUS_ERR_EN`.
- Defined: `i_mem2lsu_rsp_err`=1 sets excp bit 5 (load access fault) for loads or bit 7 (store access fault) for stores in `o_lsu2rob_info`. Load wdata is forced to 0.
- Undefined: `i_mem2lsu_rsp_err` is ignored and excp passes through unmodified.

## Test plan
- Word load at addr 0x100, rdata 0x89ABCDEF, zero-wait memory → cmd at N+1, rob valid at N+3, wdata 0x89ABCDEF.
- Signed byte load at addr 0x103, rdata 0x80112233 → wdata 0xFFFFFF80. With unsigned=1 → wdata 0x00000080.
- Short store at addr 0x102, wmask 4'b1100 → cmd_read=0, wmask 4'b1100; rob wdata 0.
- Request with excp bit 4 set (misaligned load) → no `o_lsu2mem_cmd_valid`; rob valid at N+1 with excp unchanged.
- Flush while in RSP, response arriving 2 cycles later → response is consumed, no rob valid, `i_agu2lsu_ready` stays low until the cycle after the response.
- With `HICORE_LSU_BUS_ERR_EN` defined, load response with err=1 → excp bit 5 set, wdata 0. With the macro undefined → excp unchanged.
